conv_mac_seq: RTL and testbench

Parametrised, sequential successor of the combinational 5x5 convolution block. It computes a signed fixed-point dot product of a KxK window and a KxK filter, LANES products per clock. It supports multi-channel accumulation, rounding, saturation and an overflow flag. It sits between the window/filter buffers and the output feature-map writer in the CNN datapath.

---
 rtl/conv_mac_seq_if.sv | 30 +++
 rtl/conv_mac_seq.sv | 156 +++++++++++++++
 tb/tb_conv_mac_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_seq_if.sv
// conv_mac_seq_if: request/response bundle between the window/filter buffers,
// the sequential convolution MAC and the output feature-map writer.
//   start, acc_clear      : request a dot product, optionally starting a new sum
//   window, filter        : K*K flattened signed elements, element i at [i*DATA_W +: DATA_W]
//   busy, done            : MAC in progress / one-cycle completion pulse
//   result, overflow      : rounded, saturated sum and its saturation flag
// master drives the request side, slave is the MAC itself.
interface conv_mac_seq_if #(
    parameter int DATA_W = 16,
    parameter int K      = 5
);
    logic                     start;
    logic                     acc_clear;
    logic [K*K*DATA_W-1:0]    window;
    logic [K*K*DATA_W-1:0]    filter;
    logic                     busy;
    logic                     done;
    logic [DATA_W-1:0]        result;
    logic                     overflow;

    modport master (
        output start, acc_clear, window, filter,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, acc_clear, window, filter,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential signed fixed-point KxK dot product, LANES products
// per clock, N = ceil(K*K/LANES) MAC cycles per window. Supports accumulation
// across input channels (acc_clear=0), round-half-up and output saturation.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, aborts any operation in flight
//   bus    : conv_mac_seq_if slave (start/acc_clear/window/filter in,
//            busy/done/result/overflow out, all outputs registered)
module conv_mac_seq #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 11,
    parameter int K      = 5,
    parameter int LANES  = 5,
    parameter int ACC_W  = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    conv_mac_seq_if.slave bus
);

    localparam int NE     = K * K;
    localparam int N      = (NE + LANES - 1) / LANES;
    // Operand storage is padded to a whole number of lane groups; pad slots hold 0
    localparam int NP     = N * LANES;
    localparam int IDX_W  = (NP > 1) ? $clog2(NP) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'((N - 1) * LANES);
    localparam logic [IDX_W-1:0]        LANE_STEP = IDX_W'(LANES);
    localparam logic signed [ACC_W-1:0] HALF      = ACC_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] RMAX      = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] RMIN      = ~RMAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic [IDX_W-1:0]          idx_r;
    logic signed [DATA_W-1:0]  win_r [NP];
    logic signed [DATA_W-1:0]  flt_r [NP];
    logic                      busy_r;
    logic                      done_r;
    logic [DATA_W-1:0]         result_r;
    logic                      overflow_r;

    logic signed [DATA_W-1:0]  win_in_s  [NP];
    logic signed [DATA_W-1:0]  flt_in_s  [NP];
    logic signed [PROD_W-1:0]  prod_s    [LANES];
    logic signed [ACC_W-1:0]   lane_sum_s;
    logic signed [ACC_W-1:0]   acc_next_s;

    // Round half up via arithmetic shift, then clamp to the DATA_W signed range.
    // Returns {overflow, result}.
    function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + HALF) >>> FRAC_W;
        if (r > RMAX) begin
            round_sat = {1'b1, RMAX[DATA_W-1:0]};
        end else if (r < RMIN) begin
            round_sat = {1'b1, RMIN[DATA_W-1:0]};
        end else begin
            round_sat = {1'b0, r[DATA_W-1:0]};
        end
    endfunction

    // Unflatten the operand buses into element arrays, zero-padding the tail lane group
    for (genvar g = 0; g < NP; g++) begin : g_pad
        if (g < NE) begin : g_real
            assign win_in_s[g] = bus.window[g*DATA_W +: DATA_W];
            assign flt_in_s[g] = bus.filter[g*DATA_W +: DATA_W];
        end else begin : g_zero
            assign win_in_s[g] = '0;
            assign flt_in_s[g] = '0;
        end
    end

    // One full-width signed multiplier per lane on the current element group
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod_s[l] = PROD_W'(win_r[idx_r + IDX_W'(l)]) * PROD_W'(flt_r[idx_r + IDX_W'(l)]);
    end

    // Sign-extend each lane product and sum into the accumulator width
    always_comb begin
        lane_sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s = lane_sum_s + ACC_W'(prod_s[l]);
        end
        acc_next_s = acc_r + lane_sum_s;
    end

    // Control FSM, operand latch, wrapping accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= '0;
            idx_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            overflow_r <= 1'b0;
            for (int e = 0; e < NP; e++) begin
                win_r[e] <= '0;
                flt_r[e] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        for (int e = 0; e < NP; e++) begin
                            win_r[e] <= win_in_s[e];
                            flt_r[e] <= flt_in_s[e];
                        end
                        if (bus.acc_clear) begin
                            acc_r <= '0;
                        end else begin
                            acc_r <= acc_r;
                        end
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_MAC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r                  <= '0;
                        busy_r                 <= 1'b0;
                        done_r                 <= 1'b1;
                        {overflow_r, result_r} <= round_sat(acc_next_s);
                        state_r                <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + LANE_STEP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_conv_mac_seq.sv
// tb_conv_mac_seq: directed scenarios with literal expectations plus randomized
// traffic, all checked against a transaction-level model of the MAC.
module tb_conv_mac_seq;

    localparam int DW = 16;
    localparam int NE = 25;
    localparam int NM = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_mac_seq_if #(.DATA_W(16), .K(5)) bus();
    conv_mac_seq_if #(.DATA_W(16), .K(3)) bus3();

    conv_mac_seq #(.DATA_W(16), .FRAC_W(11), .K(5), .LANES(5), .ACC_W(40)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    conv_mac_seq #(.DATA_W(16), .FRAC_W(11), .K(3), .LANES(2), .ACC_W(40)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint dot(input logic [NE*DW-1:0] w, input logic [NE*DW-1:0] f);
        longint s = 0;
        for (int i = 0; i < NE; i++) begin
            s += longint'($signed(w[i*DW +: DW])) * longint'($signed(f[i*DW +: DW]));
        end
        return s;
    endfunction

    function automatic logic [16:0] ref_out(input longint a);
        longint r;
        r = (a + 64'sd1024) >>> 11;
        if (r > 32767) return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else return {1'b0, r[15:0]};
    endfunction

    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_result = 16'h0000;
    logic        m_ovf = 1'b0;
    longint      m_acc = 0;

    // Transaction model: the whole dot product is computed when a start is accepted,
    // and published NM cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_done = 1'b0; m_result = 16'h0000; m_ovf = 1'b0; m_acc = 0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_ovf, m_result} = ref_out(m_acc);
                    m_done = 1'b1;
                end
            end else if (bus.start === 1'b1) begin
                m_acc = (bus.acc_clear ? 64'sd0 : m_acc) + dot(bus.window, bus.filter);
                m_acc = (m_acc <<< 24) >>> 24;
                m_cnt = NM;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(bus.busy), 64'(m_cnt > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("result", 64'(bus.result), 64'(m_result));
            chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_all(input logic [15:0] w, input logic [15:0] f);
        for (int i = 0; i < NE; i++) begin
            bus.window[i*DW +: DW] = w;
            bus.filter[i*DW +: DW] = f;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic op(input logic clr, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.acc_clear = clr;
        @(negedge clk);
        bus.start = 1'b0;
        bus.acc_clear = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int last_t;
        int t;
        bus.start = 1'b0; bus.acc_clear = 1'b0; bus.window = '0; bus.filter = '0;
        bus3.start = 1'b0; bus3.acc_clear = 1'b0; bus3.window = '0; bus3.filter = '0;

        #12;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_overflow", 64'(bus.overflow), 64'd0);
        #11 rst_n = 1'b1;

        // Scenario 1: 25 x 0.5*0.5
        set_all(16'h0400, 16'h0400);
        op(1'b1, lat);
        chk("s1_latency", 64'(lat), 64'd5);
        chk("s1_result", 64'(bus.result), 64'h3200);
        chk("s1_overflow", 64'(bus.overflow), 64'd0);

        // Scenario 2: negative sum, then negative saturation
        set_all(16'hF800, 16'h0400);
        op(1'b1, lat);
        chk("s2_result", 64'(bus.result), 64'h9C00);
        chk("s2_overflow", 64'(bus.overflow), 64'd0);
        set_all(16'hF800, 16'h0800);
        op(1'b1, lat);
        chk("s2_sat_result", 64'(bus.result), 64'h8000);
        chk("s2_sat_overflow", 64'(bus.overflow), 64'd1);

        // Scenario 3: channel accumulation up to positive saturation
        set_all(16'h0400, 16'h0400);
        op(1'b1, lat);
        op(1'b0, lat);
        chk("s3_acc2_result", 64'(bus.result), 64'h6400);
        chk("s3_acc2_overflow", 64'(bus.overflow), 64'd0);
        op(1'b0, lat);
        chk("s3_acc3_result", 64'(bus.result), 64'h7FFF);
        chk("s3_acc3_overflow", 64'(bus.overflow), 64'd1);

        // Scenario 4: rounding boundary
        bus.window = '0; bus.filter = '0;
        bus.window[15:0] = 16'h0001; bus.filter[15:0] = 16'h0400;
        op(1'b1, lat);
        chk("s4_round_up", 64'(bus.result), 64'h0001);
        bus.filter[15:0] = 16'h03FF;
        op(1'b1, lat);
        chk("s4_round_down", 64'(bus.result), 64'h0000);

        // Scenario 5a: continuous start, one result every 6 cycles
        set_all(16'h0400, 16'h0400);
        @(negedge clk);
        bus.start = 1'b1; bus.acc_clear = 1'b1;
        n = 0; last_t = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                t = c;
                if (last_t >= 0) chk("b2b_period", 64'(t - last_t), 64'd6);
                chk("b2b_result", 64'(bus.result), 64'h3200);
                last_t = t;
                n++;
            end
        end
        bus.start = 1'b0; bus.acc_clear = 1'b0;
        chk("b2b_count_ge3", 64'(n >= 3), 64'd1);
        repeat (8) @(negedge clk);

        // Scenario 5b: start during busy with other operands is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.acc_clear = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        set_all(16'h7FFF, 16'h7FFF);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.acc_clear = 1'b0;
        wait_done(lat);
        chk("ignore_busy_result", 64'(bus.result), 64'h3200);
        chk("ignore_busy_overflow", 64'(bus.overflow), 64'd0);
        repeat (8) @(negedge clk);

        // Scenario 6: asynchronous reset in MAC cycle 3
        set_all(16'h0400, 16'h0400);
        @(negedge clk);
        bus.start = 1'b1; bus.acc_clear = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.acc_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_overflow", 64'(bus.overflow), 64'd0);
        #5 rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        chk("arst_no_done", 64'(n), 64'd0);
        op(1'b1, lat);
        chk("arst_after_result", 64'(bus.result), 64'h3200);

        // K=3, LANES=2 instance: 9 x 1.0*1.0 = 9.0
        for (int i = 0; i < 9; i++) begin
            bus3.window[i*DW +: DW] = 16'h0800;
            bus3.filter[i*DW +: DW] = 16'h0800;
        end
        @(negedge clk);
        bus3.start = 1'b1; bus3.acc_clear = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0; bus3.acc_clear = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus3.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("k3_latency", 64'(lat), 64'd5);
        chk("k3_result", 64'(bus3.result), 64'h4800);
        chk("k3_overflow", 64'(bus3.overflow), 64'd0);

        // Randomized traffic: random starts (including during busy), channels, operands
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.acc_clear = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < NE; i++) begin
                    bus.window[i*DW +: DW] = 16'($urandom());
                    bus.filter[i*DW +: DW] = 16'($urandom());
                end
            end else begin
                for (int i = 0; i < NE; i++) begin
                    bus.window[i*DW +: DW] = 16'($urandom_range(0, 4095)) - 16'd2048;
                    bus.filter[i*DW +: DW] = 16'($urandom_range(0, 4095)) - 16'd2048;
                end
            end
        end
        bus.start = 1'b0; bus.acc_clear = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
